// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the EX stage.
//
// A multiply uses a shift-add loop over a 2*XLEN accumulator. It retires
// MUL_UNROLL multiplier bits per cycle. A divide uses a restoring loop that
// produces one quotient bit per cycle. Divide-by-zero and signed overflow
// skip the loop and go straight to DONE. Sign correction is applied in DONE.
//
// Parameters
//   XLEN        operand/result width (a multiple of MUL_UNROLL)
//   MUL_UNROLL  multiplier bits retired per cycle (1, 2, 4 or 8)
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   start_i     operation request, only looked at in IDLE
//   op_i        M-extension funct3 (MUL..REMU)
//   rs1_i       multiplicand / dividend
//   rs2_i       multiplier / divisor
//   flush_i     abort the in-flight operation, no result is produced
//   stallreq_o  stall request to the pipeline (combinational)
//   done_o      one-cycle pulse, result_o valid
//   result_o    result, held until the next done_o
module mdu_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int MUL_STEPS = XLEN / MUL_UNROLL;
  localparam int CW        = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                negLo_q, negLo_d;
  logic                negHi_q, negHi_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode for the request currently presented in IDLE
  logic            rs1Signed, rs2Signed, sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            divZero, divOvf;

  // Decode the signedness of each operand and form the operand magnitudes.
  // Taking the magnitude of the most negative value gives 100..0. As an
  // unsigned magnitude this is correct.
  always_comb begin
    rs1Signed = 1'b0;
    rs2Signed = 1'b0;
    case (op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        rs1Signed = 1'b1;
        rs2Signed = 1'b1;
      end
      3'b010:  rs1Signed = 1'b1;
      default: ;
    endcase
    sign1   = rs1Signed & rs1_i[XLEN-1];
    sign2   = rs2Signed & rs2_i[XLEN-1];
    mag1    = sign1 ? (~rs1_i + 1'b1) : rs1_i;
    mag2    = sign2 ? (~rs2_i + 1'b1) : rs2_i;
    divZero = (rs2_i == '0);
    divOvf  = ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  end

  // Multiply step: the multiplier sits in the low half of acc and is shifted
  // out LSB first. The partial product builds up in the high half. The adder
  // carry becomes the new MSB after each shift.
  logic [2*XLEN-1:0] mulAcc;
  logic [XLEN:0]     mulSum;

  always_comb begin
    mulAcc = acc_q;
    mulSum = '0;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      mulSum = {1'b0, mulAcc[2*XLEN-1:XLEN]} + (mulAcc[0] ? {1'b0, b_q} : '0);
      mulAcc = {mulSum, mulAcc[XLEN-1:1]};
    end
  end

  // Restoring divide step: acc = {remainder, dividend/quotient}. The
  // dividend's next bit shifts into the partial remainder. Each shift also
  // fills the freed LSB with the new quotient bit. When the subtraction is
  // taken the result is below the divisor, so XLEN bits are enough.
  logic [XLEN:0]       partial;
  logic [XLEN-1:0]     diff;
  logic [2*XLEN-1:0]   divAcc;

  always_comb begin
    partial = acc_q[2*XLEN-1:XLEN-1];
    diff    = partial[XLEN-1:0] - b_q;
    if (partial >= {1'b0, b_q}) begin
      divAcc = {diff, acc_q[XLEN-2:0], 1'b1};
    end else begin
      divAcc = {partial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection, evaluated in DONE. The fast paths
  // preload acc with the final quotient/remainder and clear both sign flags.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, resultNow;

  always_comb begin
    prod = negLo_q ? (~acc_q + 1'b1) : acc_q;
    quo  = negLo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem  = negHi_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 resultNow = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: resultNow = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         resultNow = quo;
      default:                resultNow = rem;
    endcase
  end

  // Next-state logic and outputs. A flush overrides everything else: the
  // FSM returns to IDLE, done_o is suppressed and result_o is not updated.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    negLo_d    = negLo_q;
    negHi_d    = negHi_q;
    result_d   = result_q;
    stallreq_o = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          stallreq_o = 1'b1;
          op_d       = op_i;
          if (!op_i[2]) begin
            state_d = MUL;
            b_d     = mag1;
            acc_d   = {{XLEN{1'b0}}, mag2};
            cnt_d   = CW'(MUL_STEPS - 1);
            negLo_d = sign1 ^ sign2;
            negHi_d = 1'b0;
          end else if (divZero) begin
            state_d = DONE;
            acc_d   = {rs1_i, {XLEN{1'b1}}};
            negLo_d = 1'b0;
            negHi_d = 1'b0;
          end else if (divOvf) begin
            state_d = DONE;
            acc_d   = {{XLEN{1'b0}}, rs1_i};
            negLo_d = 1'b0;
            negHi_d = 1'b0;
          end else begin
            state_d = DIV;
            b_d     = mag2;
            acc_d   = {{XLEN{1'b0}}, mag1};
            cnt_d   = CW'(XLEN - 1);
            negLo_d = sign1 ^ sign2;
            negHi_d = sign1;
          end
        end
      end
      MUL: begin
        stallreq_o = 1'b1;
        acc_d      = mulAcc;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DIV: begin
        stallreq_o = 1'b1;
        acc_d      = divAcc;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      default: begin
        done_o   = 1'b1;
        result_d = resultNow;
        state_d  = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d  = IDLE;
      done_o   = 1'b0;
      result_d = result_q;
    end
  end

  // The result is visible in the DONE cycle itself and then held in result_q
  assign result_o = done_o ? resultNow : result_q;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negLo_q  <= 1'b0;
      negHi_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negLo_q  <= negLo_d;
      negHi_q  <= negHi_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter. Two instances share the stimulus: one with
// MUL_UNROLL=1 and one with MUL_UNROLL=4. A table of RV32M vectors is run
// through both. Each instance has its own scoreboard queue. Hand-written
// sequences then cover flush, reset, start held through DONE, and
// start together with flush.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        stall1, done1, stall4, done4;
  logic [31:0] res1, res4;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .MUL_UNROLL(1)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .stallreq_o(stall1), .done_o(done1), .result_o(res1)
  );

  mdu_iter #(.XLEN(32), .MUL_UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .stallreq_o(stall4), .done_o(done4), .result_o(res4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] q1[$];
  logic [31:0] q4[$];
  int          passCount = 0;
  int          checkCount = 0;
  logic [31:0] lastExp = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s: no done_o within the cycle budget", name);
  endtask

  // Cycles from start to done (exclusive of the start cycle) minus one
  function automatic int iterations(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int unroll);
    if (!o[2]) return 32 / unroll;
    if (b == 32'd0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Reference RV32M behaviour built on the simulator's 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] p;
    logic [63:0] ua, ub;
    sa = a;
    sb = b;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'b000: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'b010: begin p = longint'(sa) * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation, push its expected result to both scoreboards, then
  // follow both instances cycle by cycle. Each instance is checked for the
  // stall profile, the done latency and the popped result.
  task automatic applyStimulus(input int idx, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n1, n4;
    bit got1, got4;
    n1 = iterations(o, a, b, 1);
    n4 = iterations(o, a, b, 4);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    q1.push_back(exp);
    q4.push_back(exp);
    #1;
    checkOutput($sformatf("v%0d stall t", idx), 32'(stall1), 32'd1);
    got1 = 1'b0;
    got4 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
      end
      #1;
      if (!got1) begin
        checkOutput($sformatf("v%0d stall u1 k=%0d", idx, k), 32'(stall1), 32'(k <= n1));
        if (done1) begin
          got1 = 1'b1;
          checkOutput($sformatf("v%0d latency u1", idx), 32'(k), 32'(n1 + 1));
          checkOutput($sformatf("v%0d result u1", idx), res1, q1.pop_front());
        end
      end
      if (!got4 && done4) begin
        got4 = 1'b1;
        checkOutput($sformatf("v%0d latency u4", idx), 32'(k), 32'(n4 + 1));
        checkOutput($sformatf("v%0d result u4", idx), res4, q4.pop_front());
      end
      if (got1 && got4) break;
    end
    if (!got1) begin failNow($sformatf("v%0d timeout u1", idx)); q1.delete(); end
    if (!got4) begin failNow($sformatf("v%0d timeout u4", idx)); q4.delete(); end
    lastExp = exp;
  endtask

  // Count done pulses of the unroll-1 instance over a window of cycles
  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      #1;
      if (done1) n++;
    end
  endtask

  initial begin
    int          nDone, firstK, secondK;
    logic [31:0] firstRes, secondRes;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3]  = '{3'b011, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'b101, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1};
    vecs[13] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[14] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1};
    vecs[15] = '{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};
    vecs[16] = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[17] = '{3'b001, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", 32'(stall1), 32'd0);
    checkOutput("reset done", 32'(done1), 32'd0);
    checkOutput("reset result u1", res1, 32'd0);
    checkOutput("reset result u4", res4, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) applyStimulus(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      applyStimulus(100 + i, rop, ra, rb, model(rop, ra, rb));
    end

    // Flush in the middle of a divide: no done, result unchanged
    @(negedge clk);
    op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    flush = 1'b1;
    #1;
    checkOutput("flush stall t+10", 32'(stall1), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush stall t+11", 32'(stall1), 32'd0);
    countDones(40, nDone);
    checkOutput("flush no done", 32'(nDone), 32'd0);
    checkOutput("flush result held", res1, lastExp);

    // Reset in the middle of a multiply clears every output
    @(negedge clk);
    op = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst stall", 32'(stall1), 32'd0);
    checkOutput("midrst done", 32'(done1), 32'd0);
    checkOutput("midrst result", res1, 32'd0);
    rst = 1'b0;
    countDones(40, nDone);
    checkOutput("midrst no done", 32'(nDone), 32'd0);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    op = 3'b000; rs1 = 32'd4; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    checkOutput("startflush stall", 32'(stall1), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("startflush idle", 32'(stall1), 32'd0);
    countDones(40, nDone);
    checkOutput("startflush no done", 32'(nDone), 32'd0);

    // Fast-path op with start held: one done, re-accept right after DONE
    @(negedge clk);
    op = 3'b111; rs1 = 32'h11; rs2 = 32'd0; start = 1'b1;
    #1;
    checkOutput("hold fast stall t", 32'(stall1), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("hold fast done1", 32'(done1), 32'd1);
    checkOutput("hold fast stall1", 32'(stall1), 32'd0);
    checkOutput("hold fast res1", res1, 32'h11);
    @(negedge clk);
    rs1 = 32'h22;
    #1;
    checkOutput("hold fast done2", 32'(done1), 32'd0);
    checkOutput("hold fast stall2", 32'(stall1), 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("hold fast done3", 32'(done1), 32'd1);
    checkOutput("hold fast res3", res1, 32'h22);
    @(negedge clk);
    #1;
    checkOutput("hold fast done4", 32'(done1), 32'd0);
    checkOutput("hold fast held", res1, 32'h22);

    // Multiply with start held through DONE, next op accepted at t+34
    @(negedge clk);
    op = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    nDone = 0; firstK = 0; secondK = 0; firstRes = '0; secondRes = '0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k == 34) begin rs1 = 32'd3; rs2 = 32'd5; end
      if (k == 35) start = 1'b0;
      #1;
      if (k == 34) checkOutput("hold mul accept", 32'(stall1), 32'd1);
      if (done1) begin
        nDone++;
        if (nDone == 1) begin firstK = k; firstRes = res1; end
        else if (nDone == 2) begin secondK = k; secondRes = res1; end
      end
    end
    checkOutput("hold mul done count", 32'(nDone), 32'd2);
    checkOutput("hold mul first at", 32'(firstK), 32'd33);
    checkOutput("hold mul first res", firstRes, 32'hFFFF_FFEB);
    checkOutput("hold mul second at", 32'(secondK), 32'd67);
    checkOutput("hold mul second res", secondRes, 32'd15);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
